// File: rtl/ram_bus_controller_pkg.sv
// ram_bus_controller_pkg: state encoding and default widths shared by the ram_bus_controller sequencer
package ram_bus_controller_pkg;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_ADDR_WIDTH = 3;
  typedef enum logic [3:0] {
    IDLE,
    WR_SETUP,
    WR_STROBE,
    WR_HOLD,
    RD_SETUP,
    RD_ENABLE,
    RD_CAPTURE,
    RD_RELEASE,
    CLEAR
  } state_e;
endpackage

// File: rtl/ram_bus_controller.sv
// ram_bus_controller: valid/ready requests -> tri-state RAM bus (clock_in, reset_in, req_*, rsp_*, ram_*); RAM_CLEAR_EN clears the RAM after reset
module ram_bus_controller
  import ram_bus_controller_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                  clock_in,
  input  logic                  reset_in,
  input  logic                  req_valid_in,
  output logic                  req_ready_out,
  input  logic                  req_write_in,
  input  logic [ADDR_WIDTH-1:0] req_addr_in,
  input  logic [DATA_WIDTH-1:0] req_wdata_in,
  output logic                  rsp_valid_out,
  output logic [DATA_WIDTH-1:0] rsp_rdata_out,
  output logic                  ram_we_out,
  output logic                  ram_enable_out,
  output logic [ADDR_WIDTH-1:0] ram_addr_out,
  inout  logic [DATA_WIDTH-1:0] ram_data
);
`ifdef RAM_CLEAR_EN
  localparam logic CLR_RST = 1'b1;
`else
  localparam logic CLR_RST = 1'b0;
`endif
  state_e state_q, state_d;
  logic clr_q, clr_d, we_q, we_d, en_q, en_d, drv_q, drv_d, rsp_valid_q, rsp_valid_d, accept;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  assign req_ready_out = state_q == IDLE && !clr_q && !reset_in;
  assign accept = req_valid_in && req_ready_out;
  always_comb begin
    clr_d = clr_q && !(state_q == WR_HOLD && &addr_q);
    state_d = IDLE;
    unique case (state_q)
      IDLE:             state_d = accept ? (req_write_in ? WR_SETUP : RD_SETUP) : clr_q ? CLEAR : IDLE;
      WR_SETUP, CLEAR:  state_d = WR_STROBE;
      WR_STROBE:        state_d = WR_HOLD;
      WR_HOLD:          state_d = clr_d ? CLEAR : IDLE;
      RD_SETUP:         state_d = RD_ENABLE;
      RD_ENABLE:        state_d = RD_CAPTURE;
      RD_CAPTURE:       state_d = RD_RELEASE;
      default:          state_d = IDLE;
    endcase
    we_d = state_d == WR_STROBE;
    en_d = state_d == RD_ENABLE || state_d == RD_CAPTURE;
    drv_d = state_d inside {WR_SETUP, WR_STROBE, WR_HOLD, CLEAR};
    rsp_valid_d = state_d == RD_RELEASE;
    addr_d = accept ? req_addr_in : (state_q == WR_HOLD && state_d == CLEAR) ? addr_q + ADDR_WIDTH'(1) : addr_q;
    wdata_d = clr_q ? CLEAR_VALUE : (accept && req_write_in) ? req_wdata_in : wdata_q;
    rdata_d = state_q == RD_CAPTURE ? ram_data : rdata_q;
  end
  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state_q <= IDLE;
      clr_q <= CLR_RST;
      we_q <= 1'b0;
      en_q <= 1'b0;
      drv_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      clr_q <= clr_d;
      we_q <= we_d;
      en_q <= en_d;
      drv_q <= drv_d;
      rsp_valid_q <= rsp_valid_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end
  assign ram_data = drv_q ? wdata_q : 'z;
  assign ram_we_out = we_q;
  assign ram_enable_out = en_q;
  assign ram_addr_out = addr_q;
  assign rsp_valid_out = rsp_valid_q;
  assign rsp_rdata_out = rdata_q;
endmodule

// File: tb/tb_ram_bus_controller.sv
// tb_ram_bus_controller: directed checks of ram_bus_controller against a behavioural 8x16 tri-state RAM
module tb_ram_bus_controller;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic valid = 1'b0;
  logic ready, wr_i, rsp_valid, ram_we, ram_en;
  logic [2:0] addr_i, ram_addr;
  logic [15:0] wdata_i, rdata;
  wire [15:0] ram_data;
  logic [15:0] mem [8];
  int total = 0;
  int bad = 0;
  int both_hi = 0;
  always #5 clk = ~clk;
  ram_bus_controller dut (
    .clock_in(clk),
    .reset_in(rst),
    .req_valid_in(valid),
    .req_ready_out(ready),
    .req_write_in(wr_i),
    .req_addr_in(addr_i),
    .req_wdata_in(wdata_i),
    .rsp_valid_out(rsp_valid),
    .rsp_rdata_out(rdata),
    .ram_we_out(ram_we),
    .ram_enable_out(ram_en),
    .ram_addr_out(ram_addr),
    .ram_data(ram_data)
  );
  assign ram_data = (ram_en && !ram_we) ? mem[ram_addr] : 'z;
  always @(posedge clk) if (ram_we && !ram_en) mem[ram_addr] <= ram_data;
  always @(negedge clk) if (ram_we && ram_en) both_hi++;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask
  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    chk("wr_idle", {ready, rsp_valid}, 2'b10);
    valid = 1'b1;
    wr_i = 1'b1;
    addr_i = a;
    wdata_i = d;
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    chk("wr_setup", {ready, ram_we, ram_en, ram_addr, ram_data}, {3'b000, a, d});
    @(negedge clk);
    chk("wr_strobe", {ready, ram_we, ram_en, ram_addr, ram_data}, {3'b010, a, d});
    @(negedge clk);
    chk("wr_hold", {ready, ram_we, ram_en, ram_addr, ram_data}, {3'b000, a, d});
  endtask
  task automatic rd(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    chk("rd_idle", {ready, rsp_valid}, 2'b10);
    valid = 1'b1;
    wr_i = 1'b0;
    addr_i = a;
    wdata_i = 16'hFFFF;
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    chk("rd_setup", {ready, ram_we, ram_en, rsp_valid, ram_addr}, {4'b0000, a});
    @(negedge clk);
    chk("rd_enable", {ready, ram_we, ram_en, rsp_valid, ram_addr}, {4'b0010, a});
    @(negedge clk);
    chk("rd_capture", {ready, ram_we, ram_en, rsp_valid, ram_addr}, {4'b0010, a});
    @(negedge clk);
    chk("rd_release", {ready, ram_we, ram_en, rsp_valid, rdata}, {4'b0001, d});
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
  initial begin
    int n, cnt;
    int t [3];
    wr_i = 1'b0;
    addr_i = '0;
    wdata_i = '0;
    for (int i = 0; i < 8; i++) mem[i] = 16'hDEAD;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset", {ready, ram_we, ram_en, rsp_valid, ram_addr, rdata}, 0);
    rst = 1'b0;
`ifdef RAM_CLEAR_EN
    cnt = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (ready) break;
      cnt++;
    end
    chk("clear_cycles", cnt, 24);
    for (int k = 0; k < 8; k++) rd(3'(k), 16'h0000);
`else
    @(negedge clk);
    chk("ready_after_reset", ready, 1);
`endif
    wr(3'd3, 16'hA5C3);
    rd(3'd3, 16'hA5C3);
    for (int k = 0; k < 8; k++) wr(3'(k), 16'h1000 + 16'(k));
    for (int k = 0; k < 8; k++) rd(3'(k), 16'h1000 + 16'(k));
    valid = 1'b1;
    wr_i = 1'b1;
    n = 0;
    for (int c = 0; c < 30 && n < 3; c++) begin
      @(negedge clk);
      if (ready) begin
        addr_i = 3'(n);
        wdata_i = 16'h2000 + 16'(n);
        t[n] = c;
        n++;
      end
    end
    @(negedge clk);
    valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("hs_count", n, 3);
    chk("hs_gap01", t[1] - t[0], 4);
    chk("hs_gap12", t[2] - t[1], 4);
    rd(3'd0, 16'h2000);
    rd(3'd2, 16'h2002);
    rd(3'd5, 16'h1005);
    wr(3'd5, 16'h00FF);
    rd(3'd5, 16'h00FF);
    @(negedge clk);
    valid = 1'b1;
    wr_i = 1'b0;
    addr_i = 3'd6;
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    @(negedge clk);
    chk("mid_rd_enable", ram_en, 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_reset", {ready, ram_we, ram_en, rsp_valid, ram_addr, rdata}, 0);
    rst = 1'b0;
    cnt = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (rsp_valid) cnt++;
    end
    chk("mid_no_rsp", cnt, 0);
    wr(3'd1, 16'hBEEF);
    rd(3'd1, 16'hBEEF);
    chk("we_en_exclusive", both_hi, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
